// File: rtl/rv_multicycle_seq.sv
// Multi-cycle instruction sequencer for the RV32 integer core: fetches over a
// req/ack port, walks FETCH/DECODE/EXEC/WB, owns the PC and traps on faults.
module rv_multicycle_seq #(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_PC      = '0,
    parameter int              FETCH_TIMEOUT = 16
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_run,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [31:0]     i_imem_rdata,
    output logic [31:0]     o_ir,
    output logic            o_ir_valid,
    output logic            o_alu_start,
    input  logic            i_alu_done,
    output logic            o_rf_we,
    output logic [XLEN-1:0] o_pc,
    output logic [31:0]     o_instret,
    output logic            o_trap,
    output logic [1:0]      o_trap_cause
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Counter only has to reach FETCH_TIMEOUT-1, so clog2 bits suffice.
    localparam int             TW       = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(FETCH_TIMEOUT - 1);

    logic [2:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_ir;
    logic [31:0]     r_instret;
    logic            r_trap;
    logic [1:0]      r_trap_cause;
    logic [TW-1:0]   r_tmo;
    logic            r_alu_start;

    logic            w_legal_op;
    logic            w_rd_nonzero;

    assign w_legal_op   = (r_ir[6:0] == OP_R_TYPE) || (r_ir[6:0] == OP_I_ALU);
    assign w_rd_nonzero = |r_ir[11:7];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_ir         <= '0;
            r_instret    <= '0;
            r_trap       <= 1'b0;
            r_trap_cause <= 2'b00;
            r_tmo        <= '0;
            r_alu_start  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees the
            // pre-edge register values regardless of statement order.
            r_alu_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tmo <= '0;
                    if (i_run) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (i_imem_ack) begin
                        r_ir    <= i_imem_rdata;
                        r_state <= S_DECODE;
                    end else if (r_tmo == TMO_LAST) begin
                        r_trap       <= 1'b1;
                        r_trap_cause <= CAUSE_TIMEOUT;
                        r_state      <= S_TRAP;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_DECODE: begin
                    if (w_legal_op) begin
                        r_alu_start <= 1'b1;
                        r_state     <= S_EXEC;
                    end else begin
                        r_trap       <= 1'b1;
                        r_trap_cause <= CAUSE_ILLEGAL;
                        r_state      <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    if (i_alu_done) r_state <= S_WB;
                end
                S_WB: begin
                    r_pc      <= r_pc + XLEN'(4);
                    r_instret <= r_instret + 32'd1;
                    r_tmo     <= '0;
                    r_state   <= i_run ? S_FETCH : S_IDLE;
                end
                S_TRAP:  r_state <= S_TRAP;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Every output is a function of registered state only.
    assign o_imem_req   = (r_state == S_FETCH);
    assign o_imem_addr  = r_pc;
    assign o_ir         = r_ir;
    assign o_ir_valid   = (r_state == S_DECODE) || (r_state == S_EXEC) || (r_state == S_WB);
    assign o_alu_start  = r_alu_start;
    assign o_rf_we      = (r_state == S_WB) && w_rd_nonzero;
    assign o_pc         = r_pc;
    assign o_instret    = r_instret;
    assign o_trap       = r_trap;
    assign o_trap_cause = r_trap_cause;

endmodule

// File: tb/tb_rv_multicycle_seq.sv
// Directed bench for rv_multicycle_seq: a cycle-by-cycle vector table for the
// straight-line program plus hand sequences for x0, traps, timeout and wrap.
module tb_rv_multicycle_seq;

    localparam int FT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        ack;
    logic [31:0] rdata;
    logic        done;

    logic        req, irv, as, we, trap;
    logic [31:0] addr, ir, pc, instret;
    logic [1:0]  cause;

    logic        d2_req, d2_irv, d2_as, d2_we, d2_trap;
    logic [31:0] d2_addr, d2_ir, d2_pc, d2_instret;
    logic [1:0]  d2_cause;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv_multicycle_seq #(.XLEN(32), .RESET_PC(32'h0), .FETCH_TIMEOUT(FT)) dut (
        .i_clk(clk), .i_reset(reset), .i_run(run),
        .o_imem_req(req), .o_imem_addr(addr), .i_imem_ack(ack), .i_imem_rdata(rdata),
        .o_ir(ir), .o_ir_valid(irv), .o_alu_start(as), .i_alu_done(done),
        .o_rf_we(we), .o_pc(pc), .o_instret(instret), .o_trap(trap), .o_trap_cause(cause)
    );

    rv_multicycle_seq #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .FETCH_TIMEOUT(FT)) dut_wrap (
        .i_clk(clk), .i_reset(reset), .i_run(run),
        .o_imem_req(d2_req), .o_imem_addr(d2_addr), .i_imem_ack(ack), .i_imem_rdata(rdata),
        .o_ir(d2_ir), .o_ir_valid(d2_irv), .o_alu_start(d2_as), .i_alu_done(done),
        .o_rf_we(d2_we), .o_pc(d2_pc), .o_instret(d2_instret), .o_trap(d2_trap),
        .o_trap_cause(d2_cause)
    );

    typedef struct {
        logic        run;
        logic        ack;
        logic [31:0] rdata;
        logic        done;
        logic        req;
        logic        irv;
        logic        as;
        logic        we;
        logic [31:0] pc;
        logic [31:0] instret;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; ack = 1'b0; done = 1'b0; rdata = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; ack = 1'b0; done = 1'b0; rdata = '0;

        //           run   ack   rdata          done  req   irv   as    we    pc     instret
        vecs[0]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  32'd0};
        vecs[1]  = '{1'b1, 1'b1, 32'h00940333,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0,  32'd0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0,  32'd0};
        vecs[3]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0,  32'd0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0,  32'd0};
        vecs[5]  = '{1'b1, 1'b1, 32'h800100b3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd4,  32'd1};
        vecs[6]  = '{1'b1, 1'b1, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4,  32'd1};
        vecs[7]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd4,  32'd1};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4,  32'd1};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd4,  32'd1};
        vecs[10] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd8,  32'd2};
        vecs[11] = '{1'b1, 1'b1, 32'h00a08513,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd8,  32'd2};
        vecs[12] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd8,  32'd2};
        vecs[13] = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd8,  32'd2};
        vecs[14] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd8,  32'd2};
        vecs[15] = '{1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd12, 32'd3};
        vecs[16] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd12, 32'd3};

        // Reset state
        do_reset();
        check("reset_strobes", {req, irv, as, we}, 4'b0000);
        check("reset_pc_ir", {pc, ir, instret}, 96'h0);
        check("reset_trap", {trap, cause}, 3'b000);

        // Program of three instructions, one cycle per vector
        for (int i = 0; i < 17; i++) begin
            run   = vecs[i].run;
            ack   = vecs[i].ack;
            rdata = vecs[i].rdata;
            done  = vecs[i].done;
            check($sformatf("vec%0d", i),
                  {req, irv, as, we, pc, instret, addr},
                  {vecs[i].req, vecs[i].irv, vecs[i].as, vecs[i].we,
                   vecs[i].pc, vecs[i].instret, vecs[i].pc});
            tick();
        end
        check("prog_last_ir", ir, 32'h00a08513);

        // x0 destination: no register write, but pc and instret still advance
        do_reset();
        run = 1'b1; tick();
        ack = 1'b1; rdata = 32'h00000033; tick();
        ack = 1'b0; done = 1'b1; tick();
        check("x0_exec_start", as, 1'b1);
        tick();
        check("x0_wb", {irv, we}, 2'b10);
        run = 1'b0; done = 1'b0; tick();
        check("x0_retire", {pc, instret}, {32'd4, 32'd1});

        // Illegal opcode traps at the faulting pc; run has no effect afterwards
        run = 1'b1; tick();
        check("ill_fetch_addr", {req, addr}, {1'b1, 32'd4});
        ack = 1'b1; rdata = 32'hFFFF_FFFF; tick();
        check("ill_decode", {irv, as}, 2'b10);
        ack = 1'b0; tick();
        check("ill_trap", {trap, cause, pc}, {1'b1, 2'b01, 32'd4});
        for (int k = 0; k < 6; k++) begin
            run = k[0]; ack = 1'b1; done = 1'b1;
            check($sformatf("ill_hold%0d", k),
                  {trap, cause, pc, instret, req, irv, as, we},
                  {1'b1, 2'b01, 32'd4, 32'd1, 4'b0000});
            tick();
        end
        reset = 1'b1; run = 1'b1; ack = 1'b0; done = 1'b0; tick();
        reset = 1'b0;
        check("ill_reset", {trap, cause, pc, instret, req}, {1'b0, 2'b00, 32'd0, 32'd0, 1'b0});

        // Fetch timeout: FT cycles without ack traps with cause 10
        do_reset();
        run = 1'b1; tick();
        for (int k = 0; k < FT; k++) begin
            check($sformatf("tmo_wait%0d", k), {req, trap}, 2'b10);
            tick();
        end
        check("tmo_trap", {trap, cause, req, pc}, {1'b1, 2'b10, 1'b0, 32'd0});

        // Ack on the last allowed cycle still completes the fetch
        do_reset();
        run = 1'b1; tick();
        for (int k = 0; k < FT - 1; k++) tick();
        check("tmo_edge_fetch", {req, trap}, 2'b10);
        ack = 1'b1; rdata = 32'h00940333; tick();
        check("tmo_edge_decode", {irv, trap, cause, ir}, {1'b1, 1'b0, 2'b00, 32'h00940333});
        ack = 1'b0; done = 1'b1; tick();
        tick();
        run = 1'b0; done = 1'b0; tick();
        check("tmo_edge_retire", {pc, instret, trap}, {32'd4, 32'd1, 1'b0});

        // PC wrap from 0xFFFFFFFC to 0
        do_reset();
        check("wrap_reset_pc", d2_pc, 32'hFFFF_FFFC);
        run = 1'b1; tick();
        check("wrap_fetch_addr", {d2_req, d2_addr}, {1'b1, 32'hFFFF_FFFC});
        ack = 1'b1; rdata = 32'h00940333; tick();
        ack = 1'b0; done = 1'b1; tick();
        tick();
        run = 1'b0; done = 1'b0; tick();
        check("wrap_pc", {d2_pc, d2_instret}, {32'd0, 32'd1});
        check("wrap_ref_pc", pc, 32'd4);

        // Reset asserted during EXEC returns to IDLE with strobes low
        run = 1'b1; tick();
        ack = 1'b1; rdata = 32'h00a08513; tick();
        ack = 1'b0; done = 1'b0; tick();
        check("rst_exec_entry", {irv, as}, 2'b11);
        reset = 1'b1; tick();
        reset = 1'b0; run = 1'b0;
        check("rst_exec_idle", {req, irv, as, we, trap, pc, instret}, {5'b00000, 32'd0, 32'd0});
        tick();
        check("rst_exec_stay", {req, irv, as, we}, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
